// File: rtl/bp_update_ctrl_pkg.sv
// Shared sizing for the branch-predictor update path.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
// Contents: default queue depth and address width, and the packed width of
// one update record {valid, pc, target}.
package bp_update_ctrl_pkg;

    localparam int BP_UPD_DEPTH_DEF = 4;
    localparam int BP_AW_DEF        = 32;

    // Width of one packed update record {valid, pc, target}.
    function automatic int bp_upd_wd(input int aw);
        return 1 + 2 * aw;
    endfunction

    localparam int BP_UPD_WD = 1 + 2 * BP_AW_DEF;

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Bundle of the two EX-pipe update requests and the BTB write port.
// Latency: n/a (wires only).
// Backpressure: upd_stall towards the EX pipes, btb_wr_ready from the BTB.
// Modports: master = upstream/BTB side driving requests and ready,
//           slave  = bp_update_ctrl producing stall, write port and status.
interface bp_update_ctrl_if #(
    parameter int AW    = bp_update_ctrl_pkg::BP_AW_DEF,
    parameter int DEPTH = bp_update_ctrl_pkg::BP_UPD_DEPTH_DEF
);
    import bp_update_ctrl_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic          upd0_valid;
    logic [AW-1:0] upd0_pc;
    logic [AW-1:0] upd0_target;
    logic          upd1_valid;
    logic [AW-1:0] upd1_pc;
    logic [AW-1:0] upd1_target;
    logic          upd_stall;
    logic          btb_wr_en;
    logic [AW-1:0] btb_wr_pc;
    logic [AW-1:0] btb_wr_target;
    logic          btb_wr_ready;
    logic [CW-1:0] pending_cnt;
    logic          overflow;

    modport master (
        output upd0_valid, upd0_pc, upd0_target,
        output upd1_valid, upd1_pc, upd1_target,
        output btb_wr_ready,
        input  upd_stall, btb_wr_en, btb_wr_pc, btb_wr_target,
        input  pending_cnt, overflow
    );

    modport slave (
        input  upd0_valid, upd0_pc, upd0_target,
        input  upd1_valid, upd1_pc, upd1_target,
        input  btb_wr_ready,
        output upd_stall, btb_wr_en, btb_wr_pc, btb_wr_target,
        output pending_cnt, overflow
    );

endinterface

// File: rtl/bp_upd_match.sv
// DEPTH-way PC compare of both incoming updates against the queued entries.
// Latency: combinational.
// Backpressure: none.
// Ports: entry_vld/entry_pc = queue contents, head/head_pop = entry leaving
// this cycle (excluded from matching), in0/in1 = requests, match0/match1 =
// one-hot hit vectors (at most one bit set since the queue never holds a PC twice).
module bp_upd_match
    import bp_update_ctrl_pkg::*;
#(
    parameter int DEPTH = BP_UPD_DEPTH_DEF,
    parameter int AW    = BP_AW_DEF,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         entry_vld,
    input  logic [DEPTH-1:0][AW-1:0] entry_pc,
    input  logic [PW-1:0]            head,
    input  logic                     head_pop,
    input  logic                     in0_vld,
    input  logic [AW-1:0]            in0_pc,
    input  logic                     in1_vld,
    input  logic [AW-1:0]            in1_pc,
    output logic [DEPTH-1:0]         match0,
    output logic [DEPTH-1:0]         match1
);

    logic [DEPTH-1:0] live;

    always_comb begin
        live = entry_vld;
        // A popping head is already on its way to the BTB; updating it in
        // place would lose the new target, so it must not absorb a request.
        if (head_pop) begin
            live[head] = 1'b0;
        end
        match0 = '0;
        match1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match0[i] = in0_vld & live[i] & (entry_pc[i] == in0_pc);
            match1[i] = in1_vld & live[i] & (entry_pc[i] == in1_pc);
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Coalescing circular queue from the two EX branch pipes to the single BTB write port.
// Latency: push at edge N is on btb_wr_* in cycle N+1 when the queue was empty; one pop per cycle.
// Backpressure: upd_stall when fewer than 2 slots are free; pushes beyond free space are dropped and set overflow.
// Ports: clk, rst (sync, active-high), flush (drop queue and this cycle's
// pushes), bus = bp_update_ctrl_if.slave (update requests, BTB write port,
// pending_cnt, sticky overflow).
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
#(
    parameter int DEPTH = BP_UPD_DEPTH_DEF,
    parameter int AW    = BP_AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    bp_update_ctrl_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]         vld_q;
    logic [DEPTH-1:0][AW-1:0] pc_q;
    logic [DEPTH-1:0][AW-1:0] tgt_q;
    logic [PW-1:0]            head_q;
    logic [PW-1:0]            tail_q;
    logic [CW-1:0]            count_q;
    logic                     ovf_q;

    logic                     wr_en;
    logic                     pop;
    logic [CW-1:0]            free;
    logic                     same_pc;
    logic                     u0;
    logic                     u1;
    logic [DEPTH-1:0]         match0;
    logic [DEPTH-1:0]         match1;
    logic                     need0;
    logic                     need1;
    logic                     acc0;
    logic                     acc1;
    logic                     drop;
    logic [PW-1:0]            slot0;
    logic [PW-1:0]            slot1;
    logic [CW-1:0]            n_push;

    assign wr_en = (count_q != '0);
    assign pop   = wr_en & bus.btb_wr_ready;

    // Two requests to the same PC in one cycle collapse onto pipe 1, the
    // younger one. Because upd0 is suppressed in that case, upd1 can never
    // match upd0's freshly allocated slot, so no extra compare is needed.
    assign same_pc = bus.upd0_valid & bus.upd1_valid & (bus.upd0_pc == bus.upd1_pc);
    assign u0      = bus.upd0_valid & ~same_pc;
    assign u1      = bus.upd1_valid;

    bp_upd_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .entry_vld (vld_q),
        .entry_pc  (pc_q),
        .head      (head_q),
        .head_pop  (pop),
        .in0_vld   (u0),
        .in0_pc    (bus.upd0_pc),
        .in1_vld   (u1),
        .in1_pc    (bus.upd1_pc),
        .match0    (match0),
        .match1    (match1)
    );

    always_comb begin
        // A slot leaving this cycle is reusable by this cycle's pushes.
        free   = CW'(DEPTH) - count_q + CW'(pop);
        need0  = u0 & ~(|match0);
        need1  = u1 & ~(|match1);
        acc0   = need0 & (free != '0);
        // upd1 needs one slot beyond whatever upd0 took.
        acc1   = need1 & (free > CW'(acc0));
        drop   = (need0 & ~acc0) | (need1 & ~acc1);
        slot0  = tail_q;
        slot1  = tail_q + PW'(acc0);
        n_push = CW'(acc0) + CW'(acc1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            pc_q    <= '0;
            tgt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (flush) begin
            // Any pop this cycle has already been taken by the BTB; the
            // rest of the queue and all same-cycle pushes are discarded.
            vld_q   <= '0;
            head_q  <= tail_q;
            count_q <= '0;
        end else begin
            if (pop) begin
                vld_q[head_q] <= 1'b0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (match0[i]) begin
                    tgt_q[i] <= bus.upd0_target;
                end
                if (match1[i]) begin
                    tgt_q[i] <= bus.upd1_target;
                end
            end
            // Allocation comes after the pop clear so that, on a full
            // queue, a slot freed at the head can be refilled in the same edge.
            if (acc0) begin
                vld_q[slot0] <= 1'b1;
                pc_q[slot0]  <= bus.upd0_pc;
                tgt_q[slot0] <= bus.upd0_target;
            end
            if (acc1) begin
                vld_q[slot1] <= 1'b1;
                pc_q[slot1]  <= bus.upd1_pc;
                tgt_q[slot1] <= bus.upd1_target;
            end
            head_q  <= head_q + PW'(pop);
            tail_q  <= tail_q + PW'(n_push);
            count_q <= count_q - CW'(pop) + n_push;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.btb_wr_en     = wr_en;
    assign bus.btb_wr_pc     = wr_en ? pc_q[head_q]  : '0;
    assign bus.btb_wr_target = wr_en ? tgt_q[head_q] : '0;
    assign bus.pending_cnt   = count_q;
    // No pop credit here: the stall must not depend on btb_wr_ready.
    assign bus.upd_stall     = (CW'(DEPTH) - count_q) < CW'(2);
    assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Testbench for bp_update_ctrl: directed scenarios plus randomized traffic
// against a list-based reference model, with a scoreboard of expected BTB writes.
module tb_bp_update_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    logic clk;
    logic rst;
    logic flush;

    bp_update_ctrl_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    bp_update_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   passes = 0;
    ent_t m_q[$];     // reference queue contents, oldest first
    ent_t exp_q[$];   // expected BTB writes, in delivery order
    bit   m_ovf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: the popping head leaves first, then each surviving request
    // either rewrites the queued entry with its PC or appends if space remains.
    task automatic model_apply();
        logic        v;
        logic [31:0] pc;
        logic [31:0] tg;
        bit          hit;
        ent_t        e;
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            return;
        end
        if (m_q.size() != 0 && bus.btb_wr_ready) void'(m_q.pop_front());
        if (flush) begin
            m_q.delete();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            if (p == 0) begin
                v  = bus.upd0_valid && !(bus.upd1_valid && bus.upd0_pc == bus.upd1_pc);
                pc = bus.upd0_pc;
                tg = bus.upd0_target;
            end else begin
                v  = bus.upd1_valid;
                pc = bus.upd1_pc;
                tg = bus.upd1_target;
            end
            if (v) begin
                hit = 1'b0;
                for (int i = 0; i < m_q.size(); i++) begin
                    if (m_q[i].pc == pc) begin
                        e = m_q[i];
                        e.tgt = tg;
                        m_q[i] = e;
                        hit = 1'b1;
                    end
                end
                if (!hit) begin
                    if (m_q.size() < DEPTH) begin
                        e.pc  = pc;
                        e.tgt = tg;
                        m_q.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    // Apply one cycle of inputs, queue the write the BTB should see, then
    // advance the model once the edge has been taken.
    task automatic drive(input logic v0, input logic [31:0] p0, input logic [31:0] t0,
                         input logic v1, input logic [31:0] p1, input logic [31:0] t1,
                         input logic rdy, input logic fl, input logic rs);
        rst              = rs;
        flush            = fl;
        bus.upd0_valid   = v0;
        bus.upd0_pc      = p0;
        bus.upd0_target  = t0;
        bus.upd1_valid   = v1;
        bus.upd1_pc      = p1;
        bus.upd1_target  = t1;
        bus.btb_wr_ready = rdy;
        if (!rs && m_q.size() != 0 && rdy) exp_q.push_back(m_q[0]);
        @(posedge clk);
        #1;
        model_apply();
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    // Monitor: mid-cycle, compare status outputs with the model and check
    // each BTB write against the scoreboard.
    always @(negedge clk) begin
        ent_t e;
        if (!rst) begin
            chk("pending_cnt", 64'(bus.pending_cnt), 64'(m_q.size()));
            chk("btb_wr_en", 64'(bus.btb_wr_en), 64'(m_q.size() != 0));
            chk("upd_stall", 64'(bus.upd_stall), 64'((DEPTH - m_q.size()) < 2));
            chk("overflow", 64'(bus.overflow), 64'(m_ovf));
            if (m_q.size() == 0) begin
                chk("empty_pc", 64'(bus.btb_wr_pc), 64'h0);
                chk("empty_tgt", 64'(bus.btb_wr_target), 64'h0);
            end
            if (bus.btb_wr_en && bus.btb_wr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(bus.btb_wr_pc), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_pc", 64'(bus.btb_wr_pc), 64'(e.pc));
                    chk("wr_target", 64'(bus.btb_wr_target), 64'(e.tgt));
                end
            end
        end
    end

    initial begin
        logic        v0;
        logic        v1;
        logic [31:0] p0;
        logic [31:0] p1;
        // Reset then idle.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        // Single update, delivered next cycle.
        drive(1'b1, 32'h1000_0004, 32'h1000_0100, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        // Dual push with ready low, then ordered drain.
        drive(1'b1, 32'h04, 32'hA0, 1'b1, 32'h08, 32'hB0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        // Coalescing against a queued entry and within one cycle.
        drive(1'b1, 32'h04, 32'hA0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h04, 32'hC0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        drive(1'b1, 32'h10, 32'h1, 1'b1, 32'h10, 32'h2, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        // Fill to three, overflow on a two-wide push, drain with wrap.
        drive(1'b1, 32'h04, 32'h11, 1'b1, 32'h08, 32'h22, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0C, 32'h33, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h14, 32'h44, 1'b1, 32'h18, 32'h55, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);
        // Flush mid-drain with a same-cycle push.
        drive(1'b1, 32'h20, 32'h1, 1'b1, 32'h24, 32'h2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h28, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h2C, 32'h4, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        // Randomized traffic over a small PC set to provoke coalescing.
        for (int n = 0; n < 2500; n++) begin
            v0 = ($urandom_range(0, 1) == 1);
            v1 = ($urandom_range(0, 1) == 1);
            p0 = 32'($urandom_range(0, 7)) << 2;
            p1 = 32'($urandom_range(0, 7)) << 2;
            drive(v0, p0, $urandom(), v1, p1, $urandom(),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 499) == 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        idle(1'b0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
